// File: rtl/sha256_arbiter.sv
// Two-requester round-robin front end for a single SHA-256 core: grants one block at a time,
// launches the core, aborts it after TIMEOUT cycles and returns the digest with a handshake.
module sha256_arbiter #(
  parameter int unsigned TIMEOUT = 80
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic [511:0] req0_block,
  input  logic         req1_valid,
  input  logic [511:0] req1_block,
  output logic         req0_ready,
  output logic         req1_ready,
  output logic         core_start,
  output logic [511:0] core_block,
  input  logic         core_done,
  input  logic [255:0] core_digest,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [255:0] rsp_digest,
  output logic         rsp_error,
  output logic         busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] BUSY  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // Counter is 0 in the first BUSY cycle, so TIMEOUT-2 marks the last one before abort.
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 2);

  logic [1:0]    state_q, state_d;
  logic [511:0]  block_q, block_d;
  logic          id_q, id_d;
  logic [255:0]  digest_q, digest_d;
  logic          error_q, error_d;
  logic [CW-1:0] count_q, count_d;
  logic          last_q, last_d;
  logic          grant0, grant1;

  // With both requesters valid, the one not served last wins.
  assign grant0 = req0_valid && (!req1_valid || last_q);
  assign grant1 = req1_valid && (!req0_valid || !last_q);

  assign req0_ready = (state_q == IDLE) && grant0;
  assign req1_ready = (state_q == IDLE) && grant1;
  assign core_start = (state_q == START);
  assign rsp_valid  = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign core_block = block_q;
  assign rsp_id     = id_q;
  assign rsp_digest = digest_q;
  assign rsp_error  = error_q;

  always_comb begin
    state_d  = state_q;
    block_d  = block_q;
    id_d     = id_q;
    digest_d = digest_q;
    error_d  = error_q;
    count_d  = count_q;
    last_d   = last_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          block_d = grant1 ? req1_block : req0_block;
          id_d    = grant1;
          state_d = START;
        end
      end
      START: begin
        count_d = '0;
        state_d = BUSY;
      end
      BUSY: begin
        count_d = count_q + CW'(1);
        if (core_done) begin
          digest_d = core_digest;
          error_d  = 1'b0;
          state_d  = RESP;
        end else if (count_q == LAST_COUNT) begin
          digest_d = '0;
          error_d  = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          last_d  = id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      block_q  <= '0;
      id_q     <= 1'b0;
      digest_q <= '0;
      error_q  <= 1'b0;
      count_q  <= '0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      block_q  <= block_d;
      id_q     <= id_d;
      digest_q <= digest_d;
      error_q  <= error_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: tb/tb_sha256_arbiter.sv
// Directed bench for sha256_arbiter: a transaction-level timing model checked every cycle,
// plus literal expectations for latency, grant order, timeout and reset abort.
module tb_sha256_arbiter;
  localparam int unsigned TIMEOUT = 80;
  localparam logic [511:0] ABC_BLOCK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [511:0] req0_block = '0, req1_block = '0;
  logic         req0_ready, req1_ready, core_start, rsp_valid, rsp_id, rsp_error, busy;
  logic [511:0] core_block;
  logic         core_done;
  logic         done_m = 1'b0, stray_done = 1'b0;
  logic [255:0] core_digest = '0;
  logic         rsp_ready = 1'b1;
  logic [255:0] rsp_digest;

  int           errors = 0, checks = 0;
  int           cyc = 0;
  int           core_lat = 0;
  logic [255:0] core_dig = '0;

  assign core_done = done_m | stray_done;

  sha256_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_block(req0_block),
    .req1_valid(req1_valid), .req1_block(req1_block),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .core_start(core_start), .core_block(core_block),
    .core_done(core_done), .core_digest(core_digest),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_digest(rsp_digest), .rsp_error(rsp_error),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Transaction model: one job in flight, timing derived from acceptance cycle and done cycle.
  logic         m_busy = 1'b0, m_last = 1'b1, m_id = 1'b0, m_done_seen = 1'b0;
  logic [511:0] m_blk = '0;
  logic [255:0] m_digest = '0;
  int           m_acc = 0, m_done_cyc = 0;
  logic         exp_r0, exp_r1, exp_start, exp_resp, exp_err;
  logic [255:0] exp_dig;

  always_comb begin
    exp_r0    = !m_busy && req0_valid && (!req1_valid || m_last);
    exp_r1    = !m_busy && req1_valid && (!req0_valid || !m_last);
    exp_start = m_busy && (cyc == m_acc + 1);
    exp_resp  = m_busy && (m_done_seen ? (cyc > m_done_cyc) : (cyc >= m_acc + 1 + TIMEOUT));
    exp_err   = !m_done_seen;
    exp_dig   = m_done_seen ? m_digest : '0;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_last <= 1'b1; m_id <= 1'b0; m_blk <= '0; m_done_seen <= 1'b0;
    end else if (!m_busy) begin
      if (exp_r0 || exp_r1) begin
        m_busy      <= 1'b1;
        m_acc       <= cyc;
        m_id        <= exp_r1;
        m_blk       <= exp_r1 ? req1_block : req0_block;
        m_done_seen <= 1'b0;
      end
    end else begin
      if (!m_done_seen && core_done && cyc >= m_acc + 2 && cyc <= m_acc + TIMEOUT) begin
        m_done_seen <= 1'b1;
        m_done_cyc  <= cyc;
        m_digest    <= core_digest;
      end
      if (exp_resp && rsp_ready) begin
        m_busy <= 1'b0;
        m_last <= m_id;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      check("reset_ctrl", 512'({req0_ready, req1_ready, core_start, rsp_valid, busy}), '0);
      check("reset_block", core_block, '0);
      check("reset_rsp", 512'({rsp_id, rsp_error, rsp_digest}), '0);
    end else begin
      check("ctrl", 512'({req0_ready, req1_ready, core_start, rsp_valid, busy}),
            512'({exp_r0, exp_r1, exp_start, exp_resp, m_busy}));
      check("core_block", core_block, m_blk);
      check("rsp_id", 512'(rsp_id), 512'(m_id));
      if (exp_resp) check("rsp_payload", 512'({rsp_error, rsp_digest}), 512'({exp_err, exp_dig}));
    end
  end

  // Event recorder for the literal checks.
  int acc_cyc = 0, start_cyc = 0, rsp_cnt = 0;
  bit acc_q[$];
  always @(negedge clk) begin
    if (!reset) begin
      if (req0_valid && req0_ready) begin acc_cyc = cyc; acc_q.push_back(1'b0); end
      if (req1_valid && req1_ready) begin acc_cyc = cyc; acc_q.push_back(1'b1); end
      if (core_start) start_cyc = cyc;
      if (rsp_valid) rsp_cnt++;
    end
  end

  // Core model: done pulse core_lat cycles after the start pulse; core_lat == 0 never finishes.
  initial begin
    int lat;
    logic [255:0] dig;
    forever begin
      @(negedge clk);
      if (core_start && !reset && core_lat > 0) begin
        lat = core_lat;
        dig = core_dig;
        @(posedge clk);
        repeat (lat - 1) @(posedge clk);
        #1 done_m = 1'b1; core_digest = dig;
        @(posedge clk);
        #1 done_m = 1'b0;
      end
    end
  end

  task automatic send(input bit id, input logic [511:0] blk);
    bit seen = 1'b0;
    if (id) begin req1_valid = 1'b1; req1_block = blk; end
    else begin req0_valid = 1'b1; req0_block = blk; end
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = id ? req1_ready : req0_ready;
    end
    check("accept_wait", 512'(seen), 512'(1));
    @(posedge clk);
    #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_resp(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      #1;
      if (rsp_valid) break;
    end
    check("rsp_wait", 512'(rsp_valid), 512'(1));
  endtask

  task automatic stray_pulse();
    @(posedge clk);
    #1 stray_done = 1'b1;
    @(posedge clk);
    #1 stray_done = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Single request with the "abc" block, 64-cycle core.
    core_lat = 64; core_dig = ABC_DIGEST;
    send(1'b0, ABC_BLOCK);
    wait_resp(200);
    check("abc_latency", 512'(cyc - acc_cyc), 512'(66));
    check("abc_id", 512'(rsp_id), 512'(0));
    check("abc_error", 512'(rsp_error), 512'(0));
    check("abc_digest", 512'(rsp_digest), 512'(ABC_DIGEST));
    @(posedge clk);

    // Contention straight out of reset: alternation 0,1,0,1.
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    core_lat = 3; core_dig = 256'h1111_2222;
    acc_q.delete();
    req0_block = {16{32'hA0A0_0000}}; req1_block = {16{32'hB1B1_1111}};
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 200 && acc_q.size() < 4; i++) begin
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1 req0_valid = 1'b0; req1_valid = 1'b0;
    wait_resp(50);
    check("grant_count", 512'(acc_q.size()), 512'(4));
    check("grant_order", 512'({acc_q[0], acc_q[1], acc_q[2], acc_q[3]}), 512'(4'b0101));
    @(posedge clk);

    // Timeout with a silent core.
    core_lat = 0;
    send(1'b1, {16{32'hDEAD_BEEF}});
    wait_resp(200);
    check("to_latency", 512'(cyc - start_cyc), 512'(80));
    check("to_error", 512'(rsp_error), 512'(1));
    check("to_digest", 512'(rsp_digest), 512'(0));
    check("to_id", 512'(rsp_id), 512'(1));
    @(posedge clk);

    // Done lands in the same cycle as the timeout: completion wins.
    core_lat = 79; core_dig = 256'hC0FFEE;
    send(1'b0, {16{32'h1234_5678}});
    wait_resp(200);
    check("race_latency", 512'(cyc - start_cyc), 512'(80));
    check("race_error", 512'(rsp_error), 512'(0));
    check("race_digest", 512'(rsp_digest), 512'(256'hC0FFEE));
    @(posedge clk);

    // Backpressure with a waiting requester and stray done pulses.
    stray_pulse();
    rsp_ready = 1'b0;
    core_lat = 5; core_dig = 256'hFEED_FACE;
    send(1'b0, {16{32'h5555_AAAA}});
    req1_block = {16{32'h7777_0000}}; req1_valid = 1'b1;
    wait_resp(50);
    stray_pulse();
    repeat (8) @(negedge clk);
    #1;
    check("bp_valid", 512'(rsp_valid), 512'(1));
    check("bp_digest", 512'(rsp_digest), 512'(256'hFEED_FACE));
    check("bp_hold_ready", 512'(req1_ready), 512'(0));
    rsp_ready = 1'b1;
    core_lat = 2; core_dig = 256'hB0B;
    send(1'b1, {16{32'h7777_0000}});
    wait_resp(50);
    check("bp_next_id", 512'(rsp_id), 512'(1));
    @(posedge clk);

    // Reset during BUSY; the late done must not produce a response.
    core_lat = 20; core_dig = 256'hBAD;
    send(1'b0, {16{32'h0F0F_0F0F}});
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    rsp_cnt = 0;
    repeat (30) @(negedge clk);
    #1;
    check("abort_no_rsp", 512'(rsp_cnt), 512'(0));
    core_lat = 4; core_dig = 256'h600D;
    send(1'b1, {16{32'h3C3C_3C3C}});
    wait_resp(50);
    check("after_reset_latency", 512'(cyc - acc_cyc), 512'(6));
    check("after_reset_rsp", 512'({rsp_id, rsp_error, rsp_digest}), 512'({1'b1, 1'b0, 256'h600D}));
    @(posedge clk);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
